// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer memory port: default bus widths,
// YCrCb field positions inside a 36-bit pixel word, the neutral chroma value,
// the per-cycle ZBT operation encoding and a pixel packing helper.
// -----------------------------------------------------------------------------
package fb_pkg;

  // Word address is {y[8:0], x[9:0]}; word is 6 pad bits + 3x10-bit YCrCb.
  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;

  localparam int Y_LSB  = 20;
  localparam int CR_LSB = 10;
  localparam int CB_LSB = 0;

  localparam logic [9:0] GRAY_CHROMA = 10'd512;

  // One ZBT operation is issued per cycle.
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } fb_op_e;

  function automatic logic [DATA_W-1:0] pack_pixel(input logic [9:0] y,
                                                   input logic [9:0] cr,
                                                   input logic [9:0] cb);
    logic [DATA_W-1:0] w;
    w              = '0;
    w[Y_LSB +: 10]  = y;
    w[CR_LSB +: 10] = cr;
    w[CB_LSB +: 10] = cb;
    return w;
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// -----------------------------------------------------------------------------
// fb_write_fifo
// Write buffer of DEPTH {addr, data} entries (DEPTH a power of 2, >= 2).
// Every entry address is exported together with a per-slot valid bit so the
// port can compare an incoming read address against all buffered writes.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   push, push_addr/data enqueue one entry (ignored while full)
//   pop                  dequeue the head entry (ignored while empty)
//   head_addr/head_data  oldest entry
//   full, empty          occupancy flags
//   entry_addr/entry_vld all slot addresses and their valid bits
// -----------------------------------------------------------------------------
module fb_write_fifo #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
  output logic [DEPTH-1:0]             entry_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_addr = entry_addr[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Entry storage: payload only, qualified by entry_vld.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_addr[wr_ptr] <= push_addr;
      data_mem[wr_ptr]   <= push_data;
    end
  end

  // Pointers, occupancy and slot valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_ok && (rd_ptr == PTR_W'(i)))  entry_vld[i] <= 1'b0;
        if (push_ok && (wr_ptr == PTR_W'(i))) entry_vld[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_port.sv
// -----------------------------------------------------------------------------
// frame_buffer_port
// Memory-side responder between one image-processing engine and a pipelined
// single-ported ZBT SRAM bank. Writes are buffered in a small FIFO and drained
// in idle cycles; reads have priority and a fixed latency of MEM_LATENCY+1
// cycles. A read whose address matches a buffered write, or a write still in
// the ZBT pipeline, is stalled so it can never return stale data.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rd_req/rd_addr/rd_ready    read request handshake
//   rd_valid/rd_data           one-cycle read strobe, registered data (held)
//   wr_req/wr_addr/wr_data/wr_ready   write request handshake
//   mem_addr/mem_we            registered ZBT command
//   mem_wdata/mem_wdata_oe     ZBT write data, MEM_LATENCY cycles after mem_we
//   mem_rdata                  ZBT read data
//   idle                       nothing buffered or in flight
// -----------------------------------------------------------------------------
module frame_buffer_port #(
  parameter int ADDR_W      = fb_pkg::ADDR_W,
  parameter int DATA_W      = fb_pkg::DATA_W,
  parameter int MEM_LATENCY = 2,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              idle
);

  import fb_pkg::*;

  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               wr_push;
  logic                               wr_pop;
  logic                               hazard;
  logic [ADDR_W-1:0]                  head_addr;
  logic [DATA_W-1:0]                  head_data;
  logic [WFIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [WFIFO_DEPTH-1:0]             ent_vld;
  fb_op_e                             op;

  // Write in ZBT pipeline: index 0 is the cycle mem_we is high.
  logic [MEM_LATENCY-1:0] wvld_p;
  logic [ADDR_W-1:0]      waddr_p [MEM_LATENCY];
  logic [DATA_W-1:0]      wdata_p [MEM_LATENCY];
  // Read tags: index 0 is the cycle the read address is on mem_addr.
  logic [MEM_LATENCY:0]   rvld_p;

  fb_write_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WFIFO_DEPTH)
  ) u_wfifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wr_push),
    .push_addr  (wr_addr),
    .push_data  (wr_data),
    .pop        (wr_pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_addr (ent_addr),
    .entry_vld  (ent_vld)
  );

  assign wr_ready = ~fifo_full;
  assign wr_push  = wr_req & wr_ready;

  // A pending write to the same word is either still buffered or inside the
  // ZBT pipeline; both must drain before the read may be issued.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == rd_addr)) hazard = 1'b1;
    end
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (wvld_p[i] && (waddr_p[i] == rd_addr)) hazard = 1'b1;
    end
  end

  // A full FIFO blocks reads, which forces a write to drain this cycle.
  assign rd_ready = rd_req & ~fifo_full & ~hazard;

  always_comb begin
    op = OP_NOP;
    if (rd_req && rd_ready) op = OP_READ;
    else if (!fifo_empty)   op = OP_WRITE;
  end

  assign wr_pop = (op == OP_WRITE);

  assign idle = fifo_empty & ~(|wvld_p) & ~(|rvld_p) & ~mem_wdata_oe;

  // Write payload delay line (data only, qualified by wvld_p).
  always_ff @(posedge clk) begin
    // p0: head entry captured as it is issued
    waddr_p[0] <= head_addr;
    wdata_p[0] <= head_data;
    // p1..: follow the ZBT pipeline
    for (int i = 1; i < MEM_LATENCY; i++) begin
      waddr_p[i] <= waddr_p[i-1];
      wdata_p[i] <= wdata_p[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      wvld_p       <= '0;
      rvld_p       <= '0;
    end else begin
      // p0: ZBT command issue
      case (op)
        OP_READ: begin
          mem_addr <= rd_addr;
          mem_we   <= 1'b0;
        end
        OP_WRITE: begin
          mem_addr <= head_addr;
          mem_we   <= 1'b1;
        end
        default: mem_we <= 1'b0;
      endcase
      wvld_p[0] <= (op == OP_WRITE);
      rvld_p[0] <= (op == OP_READ);
      // p1..: tags follow the ZBT pipeline
      for (int i = 1; i < MEM_LATENCY; i++) wvld_p[i] <= wvld_p[i-1];
      for (int i = 1; i <= MEM_LATENCY; i++) rvld_p[i] <= rvld_p[i-1];
      // Write data phase: bus driven only in its slot, zero otherwise.
      mem_wdata_oe <= wvld_p[MEM_LATENCY-1];
      mem_wdata    <= wvld_p[MEM_LATENCY-1] ? wdata_p[MEM_LATENCY-1] : '0;
      // Read return: mem_rdata is valid MEM_LATENCY cycles after the address.
      rd_valid <= rvld_p[MEM_LATENCY];
      if (rvld_p[MEM_LATENCY]) rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_frame_buffer_port.sv
module tb_frame_buffer_port;
  import fb_pkg::*;

  localparam int AW    = fb_pkg::ADDR_W;
  localparam int DW    = fb_pkg::DATA_W;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] word_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  rd_req, rd_ready, rd_valid;
  addr_t rd_addr;
  word_t rd_data;
  logic  wr_req, wr_ready;
  addr_t wr_addr;
  word_t wr_data;
  addr_t mem_addr;
  logic  mem_we, mem_wdata_oe, idle;
  word_t mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  frame_buffer_port #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .WFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata), .idle(idle)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory contents: ZBT model and engine-side reference ----
  word_t zbt_mem [addr_t];
  word_t ref_mem [addr_t];

  function automatic word_t dflt(input addr_t a);
    return pack_pixel(a[9:0], GRAY_CHROMA, ~a[9:0]);
  endfunction

  function automatic word_t zbt_lookup(input addr_t a);
    return zbt_mem.exists(a) ? zbt_mem[a] : dflt(a);
  endfunction

  function automatic word_t ref_lookup(input addr_t a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // ZBT model: address in cycle k, data (read or write) in cycle k+LAT.
  addr_t ad1 = '0, ad2 = '0;
  logic  we1 = 1'b0, we2 = 1'b0;
  initial mem_rdata = '0;

  always @(negedge clk) begin
    if (mem_wdata_oe) begin
      check("zbt_oe_align", {63'd0, we2}, 64'd1);
      zbt_mem[ad2] = mem_wdata;
    end
    mem_rdata = zbt_lookup(ad2);
    ad2 = ad1;
    we2 = we1;
    ad1 = mem_addr;
    we1 = mem_we;
  end

  // ---------------- scoreboard -----------------------------------------------
  typedef struct { word_t data; int due; } exp_t;
  exp_t sb [$];

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rd_valid", {63'd0, rd_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_rd_data", {28'd0, rd_data}, {28'd0, e.data});
          check("sb_rd_latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        check("sb_rd_timeout", {63'd0, rd_valid}, 64'd1);
        void'(sb.pop_front());
      end
      // read is issued ahead of a write pushed in the same cycle
      if (rd_req && rd_ready) begin
        e.data = ref_lookup(rd_addr);
        e.due  = cyc + LAT + 2;
        sb.push_back(e);
      end
      if (wr_req && wr_ready) ref_mem[wr_addr] = wr_data;
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!idle && n < 60) begin
      step();
      n++;
    end
    check({tag, "_idle"}, {63'd0, idle}, 64'd1);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  // ---------------- table of single reads ------------------------------------
  typedef struct { addr_t addr; word_t exp; } vec_t;
  vec_t  vecs [4];
  word_t stream_exp [8];
  word_t raw_a;

  initial begin
    int n;
    vecs[0] = '{19'h00004, 36'h0_1F48_0200};   // Y=0x1F4, Cr=Cb=0x200
    vecs[1] = '{19'h003FF, 36'hF_FFFF_FFFF};
    vecs[2] = '{19'h7FFFF, 36'h5_5555_5555};
    vecs[3] = '{19'h00000, 36'h0_0000_0000};
    foreach (vecs[i]) begin
      zbt_mem[vecs[i].addr] = vecs[i].exp;
      ref_mem[vecs[i].addr] = vecs[i].exp;
    end

    reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_oe", {63'd0, mem_wdata_oe}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_idle", {63'd0, idle}, 64'd1);
    check("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    reset = 1'b0;
    step();

    // single reads from the table
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = vecs[i].addr;
      #1;
      check("vec_rd_ready", {63'd0, rd_ready}, 64'd1);
      step();
      rd_req = 1'b0;
      check("vec_mem_addr", 64'(mem_addr), 64'(vecs[i].addr));
      check("vec_mem_we", {63'd0, mem_we}, 64'd0);
      step(); step();
      check("vec_rd_valid_early", {63'd0, rd_valid}, 64'd0);
      step();
      check("vec_rd_valid", {63'd0, rd_valid}, 64'd1);
      check("vec_rd_data", 64'(rd_data), 64'(vecs[i].exp));
      step();
      check("vec_rd_valid_strobe", {63'd0, rd_valid}, 64'd0);
      check("vec_rd_data_hold", 64'(rd_data), 64'(vecs[i].exp));
    end

    // write then drain
    wait_idle("pre_wr");
    wr_req = 1'b1; wr_addr = 19'h00010; wr_data = 36'h0_0808_0200;
    #1;
    check("wr_ready", {63'd0, wr_ready}, 64'd1);
    step();
    wr_req = 1'b0;
    check("wr_c0_mem_we", {63'd0, mem_we}, 64'd0);
    check("wr_c0_idle", {63'd0, idle}, 64'd0);
    step();
    check("wr_c1_mem_we", {63'd0, mem_we}, 64'd1);
    check("wr_c1_mem_addr", 64'(mem_addr), 64'h10);
    check("wr_c1_oe", {63'd0, mem_wdata_oe}, 64'd0);
    step();
    check("wr_c2_mem_we", {63'd0, mem_we}, 64'd0);
    check("wr_c2_oe", {63'd0, mem_wdata_oe}, 64'd0);
    step();
    check("wr_c3_oe", {63'd0, mem_wdata_oe}, 64'd1);
    check("wr_c3_wdata", 64'(mem_wdata), 64'h0_0808_0200);
    step();
    check("wr_c4_oe", {63'd0, mem_wdata_oe}, 64'd0);
    check("wr_c4_wdata", 64'(mem_wdata), 64'd0);
    check("wr_c4_idle", {63'd0, idle}, 64'd1);

    // read-after-write hazard
    wait_idle("pre_raw");
    raw_a = 36'h9_ABCD_1234;
    wr_req = 1'b1; wr_addr = 19'h00020; wr_data = raw_a;
    step();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 19'h00020;
    #1;
    n = 0;
    while (!rd_ready && n < 20) begin
      step();
      n++;
    end
    check("raw_stall_cycles", 64'(n), 64'd3);
    step();
    rd_req = 1'b0;
    step(); step();
    check("raw_rd_valid_early", {63'd0, rd_valid}, 64'd0);
    step();
    check("raw_rd_valid", {63'd0, rd_valid}, 64'd1);
    check("raw_rd_data", 64'(rd_data), 64'(raw_a));

    // FIFO full while reads on an unrelated address keep winning arbitration
    wait_idle("pre_full");
    rd_req = 1'b1; rd_addr = 19'h00100;
    for (int i = 0; i < DEPTH; i++) begin
      wr_req = 1'b1; wr_addr = 19'h00200 + AW'(i); wr_data = 36'h0_C0DE_0000 + DW'(i);
      #1;
      check("full_wr_ready_pre", {63'd0, wr_ready}, 64'd1);
      check("full_rd_ready_pre", {63'd0, rd_ready}, 64'd1);
      step();
    end
    wr_req = 1'b0;
    #1;
    check("full_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("full_rd_stall", {63'd0, rd_ready}, 64'd0);
    step();
    check("full_mem_we", {63'd0, mem_we}, 64'd1);
    check("full_mem_addr", 64'(mem_addr), 64'h200);
    check("full_wr_ready_free", {63'd0, wr_ready}, 64'd1);
    check("full_rd_resume", {63'd0, rd_ready}, 64'd1);
    step();
    rd_req = 1'b0;
    wait_idle("post_full");
    // read back one drained write
    rd_req = 1'b1; rd_addr = 19'h00203;
    step();
    rd_req = 1'b0;
    repeat (4) step();

    // streaming: 8 back-to-back reads of 0..7
    wait_idle("pre_stream");
    for (int j = 0; j < 8; j++) stream_exp[j] = ref_lookup(AW'(j));
    for (int k = 0; k < 12; k++) begin
      rd_req = (k < 8); rd_addr = AW'(k);
      #1;
      if (k < 8) check("stream_rd_ready", {63'd0, rd_ready}, 64'd1);
      step();
      if (k >= 3 && k <= 10) begin
        check("stream_rd_valid", {63'd0, rd_valid}, 64'd1);
        check("stream_rd_data", 64'(rd_data), 64'(stream_exp[k-3]));
      end else begin
        check("stream_rd_idle", {63'd0, rd_valid}, 64'd0);
      end
    end
    rd_req = 1'b0;

    // reset with a read in flight and two writes buffered
    wait_idle("pre_rst");
    rd_req = 1'b1; rd_addr = 19'h00050;
    wr_req = 1'b1; wr_addr = 19'h00300; wr_data = 36'h1_1111_1111;
    step();
    rd_addr = 19'h00051; wr_addr = 19'h00301; wr_data = 36'h2_2222_2222;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("mid_rst_rd_data", 64'(rd_data), 64'd0);
    check("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("mid_rst_oe", {63'd0, mem_wdata_oe}, 64'd0);
    check("mid_rst_idle", {63'd0, idle}, 64'd1);
    step(); step();
    reset = 1'b0;
    ref_mem.delete(19'h00300);
    ref_mem.delete(19'h00301);
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      check("post_rst_mem_we", {63'd0, mem_we}, 64'd0);
      check("post_rst_idle", {63'd0, idle}, 64'd1);
    end

    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_port.md
Name: frame_buffer_port

Overview:
Memory-side responder for the image-processing engines' address/data interface (read_addr/read_data, write_addr/write_data). It serves one engine's read and write requests against a single-ported, pipelined ZBT SRAM bank. Writes are buffered; reads get fixed latency and are checked against buffered writes for hazards. It sits between a processing engine (blur, rectify, etc.) and the ZBT pins.

Parameters:
ADDR_W, 19, word address width ({y[8:0], x[9:0]})
DATA_W, 36, word width (6 pad + 3x10-bit YCrCb)
MEM_LATENCY, 2, ZBT pipeline depth: cycles from address to read data / write data
WFIFO_DEPTH, 4, write buffer entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rd_req  in  1  engine requests a read this cycle
rd_addr  in  ADDR_W  read address
rd_ready  out  1  read accepted this cycle when rd_req & rd_ready
rd_valid  out  1  one-cycle strobe: rd_data valid
rd_data  out  DATA_W  registered read data
wr_req  in  1  engine offers a write
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write accepted when wr_req & wr_ready
mem_addr  out  ADDR_W  ZBT address (registered)
mem_we  out  1  ZBT write enable, active-high (registered)
mem_wdata  out  DATA_W  ZBT write data (registered)
mem_wdata_oe  out  1  drive enable for mem_wdata bus
mem_rdata  in  DATA_W  ZBT read data
idle  out  1  FIFO empty and no reads/writes in flight

Behaviour:
- Reset (async, active-high): all outputs 0, FIFO empty, pipelines cleared; idle=1 after reset. Reset mid-operation drops in-flight reads (no rd_valid) and buffered writes.
- wr_ready = !fifo_full (combinational from count). Accepted write pushed at the edge.
- hazard = rd_addr equals address of any valid FIFO entry, or of a write issued to the ZBT within the last MEM_LATENCY cycles.
- rd_ready = rd_req & !fifo_full & !hazard.
- Arbitration each cycle, one ZBT op:
  - if rd_req & rd_ready: issue READ (mem_addr<=rd_addr, mem_we<=0).
  - else if FIFO non-empty: issue WRITE from FIFO head (mem_addr<=head addr, mem_we<=1), pop.
  - else: NOP (mem_we<=0, mem_addr holds).
  - FIFO full forces write issue; reads stall until a slot frees.
- Push and pop in the same cycle: count unchanged. Push when full is impossible (wr_ready low).
- Write data timing: head data enters a MEM_LATENCY-deep delay line; mem_wdata/mem_wdata_oe asserted exactly MEM_LATENCY cycles after the mem_we=1 cycle. mem_wdata_oe is 0 otherwise.
- Read latency:
  - read accepted at edge N drives mem_addr from edge N.
  - mem_rdata sampled at edge N+MEM_LATENCY+1 into rd_data; rd_valid high for that one cycle.
  - Total: rd_valid exactly 3 cycles after acceptance at default parameters.
  - Back-to-back reads return in order, one per cycle; rd_data holds between strobes.
- Read-after-write: ordering is guaranteed by hazard stall. A read never returns data older than an accepted write to the same address.
- idle = fifo_empty & no read tag or write-data stage in flight.

Decomposition:
- Package fb_pkg: ADDR_W, DATA_W, field positions Y_LSB=20 / CR_LSB=10 / CB_LSB=0, GRAY_CHROMA=10'd512.
- Sub-module fb_write_fifo: WFIFO_DEPTH entries of {addr,data}, push/pop/full/empty. Exposes all entry addresses plus valid bits for the hazard compare.

Test Plan:
- Single read: rd_req at addr 0x00004 with mem model returning 0x0_1F4_200_200 -> rd_ready=1; mem_addr=0x00004, mem_we=0 next cycle; rd_valid with rd_data=0x0_1F4_200_200 3 cycles after acceptance.
- Write then drain: wr 0x00010 <- 0x0_080_200_200, no reads -> mem_we=1 with mem_addr=0x00010 next cycle; mem_wdata=0x0_080_200_200 with oe=1 two cycles later; idle returns 1.
- RAW hazard: write 0x00020 <- A, immediately rd_req 0x00020 -> rd_ready=0 until the write has issued and cleared MEM_LATENCY; the read then returns A.
- FIFO full: 4 writes while rd_req held on an unrelated address -> wr_ready=0 after the 4th; a write issues, wr_ready=1 next cycle; reads resume after the FIFO is no longer full.
- Streaming: 8 back-to-back reads of 0..7 -> 8 consecutive rd_valid cycles, data in address order.
- Reset mid-flight: assert reset 1 cycle after a read is accepted and 2 writes are buffered -> all outputs 0 immediately, no rd_valid, no mem_we after deassertion, idle=1.
